ahb_stream_bridge: RTL and testbench

// - AHB-Lite slave linking the bus to a streaming compute engine (DDS/aligners/array).
// - Bus writes push words into an input FIFO (IFF) that drains to the engine over valid/ready.
// - Engine results land in an output FIFO (OFF) that bus reads pop.
// - Adds register decode, INCR bursts, HSIZE checking, two-cycle AHB ERROR responses
//   and a managed engine reset.

---
 rtl/ahb_stream_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_ahb_stream_bridge.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_stream_bridge.sv
// ahb_stream_bridge
//
// AHB-Lite slave that connects the bus to a streaming compute engine.
//   - Bus writes to DATA push words into an input FIFO (IFF) that drains to the
//     engine over tx_valid/tx_ready.
//   - Engine results arrive on rx_valid/rx_ready into an output FIFO (OFF) that
//     bus reads of DATA pop.
//   - Register map on HADDR[3:2]: 0 DATA, 1 STATUS (RO), 2 CTRL, 3 IRQCFG.
//   - Illegal HSIZE, IFF overflow, OFF underflow and STATUS writes get a
//     two-cycle ERROR response and change no state.
//   - eng_rst is a 2-cycle engine reset: after HRESET, on a CTRL[0] write, or
//     (CTRL[1] auto mode) when the OFF drains empty after new results. While
//     eng_rst is high the IFF is flushed.
//
// Optional feature: define AHB_STREAM_IRQ_EN to build the OFF-level interrupt
// (IRQCFG register and irq output). Without it, irq is 0 and IRQCFG reads 0
// and ignores writes.
//
// Ports
//   HCLK, HRESET           clock, synchronous active-high reset
//   HSEL..HWDATA           AHB-Lite slave inputs (HREADY is the bus-wide ready)
//   HRDATA, HREADYOUT,     AHB-Lite slave outputs; HRDATA is registered
//   HRESP
//   tx_data/valid/ready    IFF head towards the engine
//   rx_data/valid/ready    engine results into the OFF
//   eng_rst                active-high engine reset
//   irq                    OFF level interrupt

module ahb_stream_bridge_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count define
  // validity, and a reset here would turn RAM into a wide flop array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module ahb_stream_bridge #(
  parameter int W         = 32,
  parameter int AW        = 12,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic          HWRITE,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [W-1:0]  HWDATA,
  output logic [W-1:0]  HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [W-1:0]  tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [W-1:0]  rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          eng_rst,
  output logic          irq
);
  localparam logic [2:0] SIZE_CODE = (W == 64) ? 3'd3 : 3'd2;
  localparam int ILW  = $clog2(IN_DEPTH) + 1;
  localparam int OLW  = $clog2(OUT_DEPTH) + 1;
  localparam int ISW  = ILW + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_IRQCFG = 2'd3
  } reg_e;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  state_e         state, state_nx;

  // Address-phase decode
  logic           accept;
  reg_e           ap_reg;
  logic           size_err, wr_full_err, rd_empty_err, wr_status_err;
  logic           ap_err, ap_ok, rd_ok;

  // Data-phase controls latched from the address phase
  logic           dp_wr;
  reg_e           dp_reg;
  logic           dp_push_pend;

  // FIFO plumbing
  logic           iff_push, iff_pop, iff_full, iff_empty;
  logic [ILW-1:0] iff_level;
  logic [W-1:0]   iff_rdata;
  logic           off_push, off_pop, off_full, off_empty;
  logic [OLW-1:0] off_level;
  logic [W-1:0]   off_rdata;

  // Control / engine reset
  logic           ctrl_auto;
  logic           ctrl_wr;
  logic           rx_seen;
  logic [1:0]     eng_cnt;
  logic           auto_trig, soft_rst, eng_load;

  logic [31:0]    status_word;
  logic [31:0]    irqcfg_word;
  logic [W-1:0]   rd_mux;

  logic           unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HADDR[AW-1:4], HADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Address phase. Transfers presented during the first ERROR cycle are
  // ignored even if HREADY were high.
  // ---------------------------------------------------------------------------
  assign accept = HSEL & HREADY & HTRANS[1] & (state != ST_ERR1);
  assign ap_reg = reg_e'(HADDR[3:2]);

  // The word whose push is still in its data phase counts against capacity.
  assign dp_push_pend = dp_wr & (dp_reg == REG_DATA);

  assign size_err      = (HSIZE != SIZE_CODE);
  assign wr_full_err   = HWRITE & (ap_reg == REG_DATA) &
                         (({1'b0, iff_level} + ISW'(dp_push_pend)) == ISW'(IN_DEPTH));
  assign rd_empty_err  = ~HWRITE & (ap_reg == REG_DATA) & off_empty;
  assign wr_status_err = HWRITE & (ap_reg == REG_STATUS);

  assign ap_err = accept & (size_err | wr_full_err | rd_empty_err | wr_status_err);
  assign ap_ok  = accept & ~ap_err;
  assign rd_ok  = ap_ok & ~HWRITE;

  // ---------------------------------------------------------------------------
  // Response FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_OKAY;
    else        state <= state_nx;
  end

  // NOTE: every output of a combinational block is given a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state)
      ST_OKAY: begin
        if (ap_err) state_nx = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP    = 1'b1;
        state_nx = ap_err ? ST_ERR1 : ST_OKAY;
      end
      default: state_nx = ST_OKAY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data phase: writes take HWDATA one cycle after their address phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_wr  <= 1'b0;
      dp_reg <= REG_DATA;
    end else begin
      dp_wr  <= ap_ok & HWRITE;
      dp_reg <= ap_reg;
    end
  end

  assign iff_push = dp_push_pend;
  assign ctrl_wr  = dp_wr & (dp_reg == REG_CTRL);

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  ahb_stream_bridge_fifo #(.WIDTH(W), .DEPTH(IN_DEPTH)) u_iff (
    .clk   (HCLK),
    .rst   (HRESET),
    .flush (eng_rst),
    .push  (iff_push),
    .wdata (HWDATA),
    .pop   (iff_pop),
    .rdata (iff_rdata),
    .level (iff_level),
    .full  (iff_full),
    .empty (iff_empty)
  );

  ahb_stream_bridge_fifo #(.WIDTH(W), .DEPTH(OUT_DEPTH)) u_off (
    .clk   (HCLK),
    .rst   (HRESET),
    .flush (1'b0),
    .push  (off_push),
    .wdata (rx_data),
    .pop   (off_pop),
    .rdata (off_rdata),
    .level (off_level),
    .full  (off_full),
    .empty (off_empty)
  );

  // The engine sees nothing while it is being reset and the IFF is flushing.
  assign tx_valid = ~iff_empty & ~eng_rst;
  assign tx_data  = iff_rdata;
  assign iff_pop  = tx_valid & tx_ready;

  assign rx_ready = ~off_full;
  assign off_push = rx_valid & rx_ready;
  assign off_pop  = rd_ok & (ap_reg == REG_DATA);

  // ---------------------------------------------------------------------------
  // CTRL and engine reset
  // ---------------------------------------------------------------------------
  assign soft_rst  = ctrl_wr & HWDATA[0];
  assign auto_trig = ctrl_auto & rx_seen & off_empty & (eng_cnt == 2'd0);
  assign eng_load  = soft_rst | auto_trig;
  assign eng_rst   = (eng_cnt != 2'd0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_auto <= 1'b0;
      rx_seen   <= 1'b0;
      eng_cnt   <= 2'd2;  // held at 2 in reset -> 2 cycles high after release
    end else begin
      if (ctrl_wr) ctrl_auto <= HWDATA[1];
      // A result arriving in the same cycle as a reset still counts as new.
      if (off_push)      rx_seen <= 1'b1;
      else if (eng_load) rx_seen <= 1'b0;
      if (eng_load)            eng_cnt <= 2'd2;
      else if (eng_cnt != 2'd0) eng_cnt <= eng_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional OFF-level interrupt
  // ---------------------------------------------------------------------------
`ifdef AHB_STREAM_IRQ_EN
  logic           irq_wr;
  logic [7:0]     irq_thr;
  logic           irq_en;
  logic           irq_pend;
  logic           irq_cond_q;
  logic           irq_cond_nx;
  logic [OLW-1:0] off_level_nx;

  assign irq_wr = dp_wr & (dp_reg == REG_IRQCFG);

  // Evaluate the condition on the level the OFF will hold after this edge, so
  // pending rises together with the push that reaches the threshold.
  assign off_level_nx = off_level + OLW'(off_push) - OLW'(off_pop);
  assign irq_cond_nx  = irq_en & (32'(off_level_nx) >= 32'(irq_thr));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_thr    <= '0;
      irq_en     <= 1'b0;
      irq_pend   <= 1'b0;
      irq_cond_q <= 1'b0;
    end else begin
      irq_cond_q <= irq_cond_nx;
      if (irq_wr) begin
        irq_thr <= HWDATA[7:0];
        irq_en  <= HWDATA[8];
      end
      // Pending latches on the rising condition so a W1C is not undone while
      // the level simply stays above threshold; a fresh set beats a clear.
      if (irq_cond_nx & ~irq_cond_q)  irq_pend <= 1'b1;
      else if (irq_wr & HWDATA[9])    irq_pend <= 1'b0;
    end
  end

  assign irq         = irq_pend & irq_en;
  assign irqcfg_word = {22'd0, irq_pend, irq_en, irq_thr};
`else
  assign irq         = 1'b0;
  assign irqcfg_word = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: captured into HRDATA on the address-phase edge.
  // ---------------------------------------------------------------------------
  assign status_word = {14'd0, off_empty, iff_full, 8'(off_level), 8'(iff_level)};

  always_comb begin
    rd_mux = '0;
    unique case (ap_reg)
      REG_DATA:   rd_mux = off_rdata;
      REG_STATUS: rd_mux = W'(status_word);
      REG_CTRL:   rd_mux = W'({ctrl_auto, 1'b0});  // bit 0 self-clears
      REG_IRQCFG: rd_mux = W'(irqcfg_word);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET)     HRDATA <= '0;
    else if (rd_ok) HRDATA <= rd_mux;
  end
endmodule

// File: tb/tb_ahb_stream_bridge.sv
// Directed testbench for ahb_stream_bridge (W=32, depths 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. HREADY is looped back from HREADYOUT (single-slave bus).
module tb_ahb_stream_bridge;
  localparam int W  = 32;
  localparam int AW = 12;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SZ_W   = 3'd2;

  localparam logic [1:0] R_DATA   = 2'd0;
  localparam logic [1:0] R_STATUS = 2'd1;
  localparam logic [1:0] R_CTRL   = 2'd2;
  localparam logic [1:0] R_IRQCFG = 2'd3;

`ifdef AHB_STREAM_IRQ_EN
  localparam logic        EXP_IRQ_HI    = 1'b1;
  localparam logic [31:0] EXP_CFG_PEND  = 32'h0000_0303;
  localparam logic [31:0] EXP_CFG_CLR   = 32'h0000_0103;
`else
  localparam logic        EXP_IRQ_HI    = 1'b0;
  localparam logic [31:0] EXP_CFG_PEND  = 32'h0000_0000;
  localparam logic [31:0] EXP_CFG_CLR   = 32'h0000_0000;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          HSEL = 1'b0;
  logic [AW-1:0] HADDR = '0;
  logic          HWRITE = 1'b0;
  logic [1:0]    HTRANS = T_IDLE;
  logic [2:0]    HSIZE = SZ_W;
  logic          HREADY;
  logic [W-1:0]  HWDATA = '0;
  logic [W-1:0]  HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          eng_rst;
  logic          irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] pend_wdata = '0;
  logic        s_ready, s_resp;
  logic [31:0] s_rdata;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_stream_bridge #(.W(W), .AW(AW), .IN_DEPTH(8), .OUT_DEPTH(8)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .eng_rst   (eng_rst),
    .irq       (irq)
  );

  // One bus cycle: present an address phase plus the write data of the previous
  // beat, then sample the response of the previous beat's data phase.
  task automatic drive(input logic [1:0] trans, input logic wr, input logic [1:0] rg,
                       input logic [2:0] size, input logic [31:0] data);
    HSEL   = (trans != T_IDLE);
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = {8'h00, rg, 2'b00};
    HSIZE  = size;
    HWDATA = pend_wdata;
    pend_wdata = data;
    @(negedge HCLK);
    s_ready = HREADYOUT;
    s_resp  = HRESP;
    s_rdata = HRDATA;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    drive(T_IDLE, 1'b0, R_DATA, SZ_W, 32'h0);
  endtask

  task automatic read_reg(input logic [1:0] rg, output logic [31:0] data,
                          output logic ok);
    drive(T_NSEQ, 1'b0, rg, SZ_W, 32'h0);
    idle();
    data = s_rdata;
    ok   = s_ready & ~s_resp;
  endtask

  task automatic write_reg(input logic [1:0] rg, input logic [31:0] data,
                           output logic ok);
    drive(T_NSEQ, 1'b1, rg, SZ_W, data);
    idle();
    ok = s_ready & ~s_resp;
  endtask

  task automatic push_rx(input logic [31:0] data);
    rx_valid = 1'b1;
    rx_data  = data;
    @(posedge HCLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        ok;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, eng_rst, irq, tx_valid, rx_ready} !== 6'b101001) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 101001",
               {HREADYOUT, HRESP, eng_rst, irq, tx_valid, rx_ready});
    end
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_hrdata: got %h expected 00000000", HRDATA);
    end
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++;
      if (eng_rst !== (i < 2)) begin
        errors++;
        $display("FAIL reset_eng_rst_%0d: got %b expected %b", i, eng_rst, (i < 2));
      end
    end
    @(posedge HCLK);
    #1;
    read_reg(R_STATUS, rd, ok);
    checks++;
    if (rd !== 32'h0002_0000 || !ok) begin
      errors++;
      $display("FAIL reset_status: got %h ok=%b expected 00020000 ok=1", rd, ok);
    end
  endtask

  task automatic test_burst_write();
    logic [31:0] exp_tx [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] rd;
    logic        ok;
    int          bad = 0;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive((i == 0) ? T_NSEQ : T_SEQ, 1'b1, R_DATA, SZ_W, exp_tx[i]);
      if (i > 0 && (!s_ready || s_resp)) bad++;
    end
    idle();
    if (!s_ready || s_resp) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL burst_resp: got %0d non-OKAY beats expected 0", bad);
    end
    read_reg(R_STATUS, rd, ok);
    checks++;
    if (rd !== 32'h0002_0004) begin
      errors++;
      $display("FAIL burst_status: got %h expected 00020004", rd);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      checks++;
      if (!tx_valid || tx_data !== exp_tx[i]) begin
        errors++;
        $display("FAIL burst_tx_%0d: got v=%b %h expected v=1 %h", i, tx_valid, tx_data, exp_tx[i]);
      end
      @(posedge HCLK);
      #1;
    end
    tx_ready = 1'b0;
    @(negedge HCLK);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_drained: got tx_valid=%b expected 0", tx_valid);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic        ok;
    int          bad = 0;
    for (int i = 1; i <= 9; i++) begin
      drive((i == 1) ? T_NSEQ : T_SEQ, 1'b1, R_DATA, SZ_W, 32'(i));
      if (i > 1 && (!s_ready || s_resp)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovf_first8: got %0d non-OKAY beats expected 0", bad);
    end
    idle();
    checks++;
    if ({s_ready, s_resp} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_err_cycle1: got ready/resp %b expected 01", {s_ready, s_resp});
    end
    idle();
    checks++;
    if ({s_ready, s_resp} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_err_cycle2: got ready/resp %b expected 11", {s_ready, s_resp});
    end
    read_reg(R_STATUS, rd, ok);
    checks++;
    if (rd !== 32'h0003_0008) begin
      errors++;
      $display("FAIL ovf_status: got %h expected 00030008", rd);
    end
    tx_ready = 1'b1;
    repeat (8) @(posedge HCLK);
    #1 tx_ready = 1'b0;
    @(negedge HCLK);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ninth_dropped: got tx_valid=%b expected 0", tx_valid);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_empty_read();
    logic [31:0] rd;
    logic        ok;
    read_reg(R_STATUS, rd, ok);  // HRDATA now holds 00020000
    drive(T_NSEQ, 1'b0, R_DATA, SZ_W, 32'h0);
    idle();
    checks++;
    if ({s_ready, s_resp} !== 2'b01 || s_rdata !== 32'h0002_0000) begin
      errors++;
      $display("FAIL empty_rd_cycle1: got %b %h expected 01 00020000", {s_ready, s_resp}, s_rdata);
    end
    idle();
    checks++;
    if ({s_ready, s_resp} !== 2'b11 || s_rdata !== 32'h0002_0000) begin
      errors++;
      $display("FAIL empty_rd_cycle2: got %b %h expected 11 00020000", {s_ready, s_resp}, s_rdata);
    end
    push_rx(32'h0000_CAFE);
    read_reg(R_DATA, rd, ok);
    checks++;
    if (rd !== 32'h0000_CAFE || !ok) begin
      errors++;
      $display("FAIL empty_rd_then_data: got %h ok=%b expected 0000cafe ok=1", rd, ok);
    end
  endtask

  task automatic test_bad_size_and_status_write();
    logic [31:0] rd;
    logic        ok;
    drive(T_NSEQ, 1'b1, R_DATA, 3'd0, 32'h55);
    idle();
    checks++;
    if ({s_ready, s_resp} !== 2'b01) begin
      errors++;
      $display("FAIL hsize_err_cycle1: got %b expected 01", {s_ready, s_resp});
    end
    idle();
    checks++;
    if ({s_ready, s_resp} !== 2'b11) begin
      errors++;
      $display("FAIL hsize_err_cycle2: got %b expected 11", {s_ready, s_resp});
    end
    write_reg(R_STATUS, 32'hFFFF_FFFF, ok);
    checks++;
    if ({s_ready, s_resp} !== 2'b01) begin
      errors++;
      $display("FAIL status_wr_err: got %b expected 01", {s_ready, s_resp});
    end
    idle();
    read_reg(R_STATUS, rd, ok);
    checks++;
    if (rd !== 32'h0002_0000) begin
      errors++;
      $display("FAIL hsize_status: got %h expected 00020000", rd);
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] rd;
    logic        ok;
    drive(T_NSEQ, 1'b1, R_DATA, SZ_W, 32'hA1);
    write_reg(R_CTRL, 32'h1, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++;
      if (eng_rst !== (i < 2)) begin
        errors++;
        $display("FAIL soft_eng_rst_%0d: got %b expected %b", i, eng_rst, (i < 2));
      end
    end
    @(posedge HCLK);
    #1;
    read_reg(R_STATUS, rd, ok);
    checks++;
    if (rd !== 32'h0002_0000) begin
      errors++;
      $display("FAIL soft_iff_flushed: got %h expected 00020000", rd);
    end
    read_reg(R_CTRL, rd, ok);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_selfclear: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_auto_reset();
    logic [31:0] rd;
    logic        ok;
    write_reg(R_CTRL, 32'h2, ok);
    read_reg(R_CTRL, rd, ok);
    checks++;
    if (rd !== 32'h2 || eng_rst !== 1'b0) begin
      errors++;
      $display("FAIL auto_ctrl_rd: got %h eng_rst=%b expected 00000002 eng_rst=0", rd, eng_rst);
    end
    push_rx(32'hBEEF);
    read_reg(R_DATA, rd, ok);
    checks++;
    if (rd !== 32'hBEEF) begin
      errors++;
      $display("FAIL auto_rd_data: got %h expected 0000beef", rd);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++;
      if (eng_rst !== (i < 2)) begin
        errors++;
        $display("FAIL auto_eng_rst_%0d: got %b expected %b", i, eng_rst, (i < 2));
      end
    end
    @(posedge HCLK);
    #1;
    write_reg(R_CTRL, 32'h0, ok);
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic        ok;
    write_reg(R_IRQCFG, 32'h103, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL irqcfg_wr_resp: got ok=%b expected 1", ok);
    end
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 32'hD0 + 32'(i);
      @(negedge HCLK);
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL irq_early_%0d: got %b expected 0", i, irq);
      end
      @(posedge HCLK);
      #1;
    end
    rx_valid = 1'b0;
    @(negedge HCLK);
    checks++;
    if (irq !== EXP_IRQ_HI) begin
      errors++;
      $display("FAIL irq_after_third: got %b expected %b", irq, EXP_IRQ_HI);
    end
    @(posedge HCLK);
    #1;
    read_reg(R_IRQCFG, rd, ok);
    checks++;
    if (rd !== EXP_CFG_PEND) begin
      errors++;
      $display("FAIL irqcfg_pending: got %h expected %h", rd, EXP_CFG_PEND);
    end
    write_reg(R_IRQCFG, 32'h303, ok);
    @(negedge HCLK);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_w1c: got %b expected 0", irq);
    end
    @(posedge HCLK);
    #1;
    read_reg(R_IRQCFG, rd, ok);
    checks++;
    if (rd !== EXP_CFG_CLR) begin
      errors++;
      $display("FAIL irqcfg_cleared: got %h expected %h", rd, EXP_CFG_CLR);
    end
  endtask

  // Drains the three results left by test_irq with back-to-back DATA reads.
  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        ok;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive((i == 0) ? T_NSEQ : T_SEQ, 1'b0, R_DATA, SZ_W, 32'h0);
      else       idle();
      if (i > 0) begin
        checks++;
        if (s_rdata !== 32'hD0 + 32'(i - 1) || !s_ready || s_resp) begin
          errors++;
          $display("FAIL b2b_read_%0d: got %h r=%b e=%b expected %h r=1 e=0",
                   i - 1, s_rdata, s_ready, s_resp, 32'hD0 + 32'(i - 1));
        end
      end
    end
    read_reg(R_STATUS, rd, ok);
    checks++;
    if (rd !== 32'h0002_0000) begin
      errors++;
      $display("FAIL b2b_status: got %h expected 00020000", rd);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd;
    logic        ok;
    drive(T_NSEQ, 1'b1, R_DATA, SZ_W, 32'h77);
    HSEL = 1'b0;
    HTRANS = T_IDLE;
    HWDATA = pend_wdata;
    pend_wdata = '0;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    read_reg(R_STATUS, rd, ok);
    checks++;
    if (rd !== 32'h0002_0000) begin
      errors++;
      $display("FAIL mid_reset_dropped: got %h expected 00020000", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_burst_write();
    test_overflow();
    test_empty_read();
    test_bad_size_and_status_write();
    test_soft_reset();
    test_auto_reset();
    test_irq();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
